// File: rtl/ex_pipe_pkg.sv
// ex_pipe_pkg: shared constants and types for the EX/MEM pipeline back end
//   NZCV bit indices, default widths, control bundle type and its bubble value
package ex_pipe_pkg;
    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_REG_ADDR_W = 4;
    localparam int DEF_OFFS_W = 24;
    typedef struct packed {
        logic valid;
        logic wb_en;
        logic mem_r_en;
        logic mem_w_en;
    } ctrl_t;
    localparam int CTRL_W = $bits(ctrl_t);
    localparam ctrl_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/ex_pipe_reg.sv
// ex_pipe_reg: pipeline register slice with freeze (hold) and flush (bubble)
//   clk, rst (async active-low), freeze, flush, d_in[WIDTH] -> q_out[WIDTH]
//   On flush, bits set in BUBBLE_MASK take BUBBLE_VAL; the rest keep their value.
module ex_pipe_reg #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] BUBBLE_MASK = '0,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);
    logic [WIDTH-1:0] data_q, data_d;
    // flush wins over freeze so a stalled slot can still be killed
    always_comb data_d = flush ? (data_q & ~BUBBLE_MASK) | (BUBBLE_VAL & BUBBLE_MASK)
                       : freeze ? data_q : d_in;
    always_ff @(posedge clk or negedge rst)
        if (!rst) data_q <= '0;
        else data_q <= data_d;
    assign q_out = data_q;
endmodule

// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: EX/MEM boundary register, NZCV status, branch target, hazard taps
//   in : clk, rst (async active-low), in_valid, freeze, flush, control bits,
//        alu_res_in, val_rm_in, dest_in, flags_in, pc_in, offset_in
//   out: registered EX/MEM bundle, status_out, combinational branch and
//        EX-side hazard info, registered MEM-side hazard info
module ex_stage_pipe
    import ex_pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int OFFS_W = DEF_OFFS_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  wb_en_in,
    input  logic                  mem_r_en_in,
    input  logic                  mem_w_en_in,
    input  logic                  status_w_en_in,
    input  logic                  branch_taken_in,
    input  logic [DATA_W-1:0]     alu_res_in,
    input  logic [DATA_W-1:0]     val_rm_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    input  logic [3:0]            flags_in,
    input  logic [ADDR_W-1:0]     pc_in,
    input  logic [OFFS_W-1:0]     offset_in,
    output logic                  valid_out,
    output logic                  wb_en_out,
    output logic                  mem_r_en_out,
    output logic                  mem_w_en_out,
    output logic [DATA_W-1:0]     alu_res_out,
    output logic [DATA_W-1:0]     val_rm_out,
    output logic [REG_ADDR_W-1:0] dest_out,
    output logic [3:0]            status_out,
    output logic                  branch_taken_out,
    output logic [ADDR_W-1:0]     branch_addr_out,
    output logic                  hz_ex_wb_en,
    output logic [REG_ADDR_W-1:0] hz_ex_dest,
    output logic                  hz_mem_wb_en,
    output logic [REG_ADDR_W-1:0] hz_mem_dest
);
    localparam int PAY_W = 2 * DATA_W + REG_ADDR_W;
    localparam int BUNDLE_W = CTRL_W + PAY_W;
    ctrl_t ctrl_in, ctrl_out;
    logic [BUNDLE_W-1:0] bundle_q;
    logic [3:0] status_q, status_d;
    logic [ADDR_W-1:0] offs_ext;
    logic q;
    assign q = in_valid & ~flush;
    always_comb begin
        ctrl_in.valid    = in_valid;
        ctrl_in.wb_en    = wb_en_in & in_valid;
        ctrl_in.mem_r_en = mem_r_en_in & in_valid;
        ctrl_in.mem_w_en = mem_w_en_in & in_valid;
    end
    // bubble clears only the control bits; data/dest keep their old values
    ex_pipe_reg #(
        .WIDTH(BUNDLE_W),
        .BUBBLE_MASK({{CTRL_W{1'b1}}, {PAY_W{1'b0}}}),
        .BUBBLE_VAL({CTRL_BUBBLE, {PAY_W{1'b0}}})
    ) u_reg (
        .clk(clk),
        .rst(rst),
        .freeze(freeze),
        .flush(flush),
        .d_in({ctrl_in, alu_res_in, val_rm_in, dest_in}),
        .q_out(bundle_q)
    );
    assign {ctrl_out, alu_res_out, val_rm_out, dest_out} = bundle_q;
    assign valid_out = ctrl_out.valid;
    assign wb_en_out = ctrl_out.wb_en;
    assign mem_r_en_out = ctrl_out.mem_r_en;
    assign mem_w_en_out = ctrl_out.mem_w_en;
    always_comb status_d = (status_w_en_in & q & ~freeze) ? flags_in : status_q;
    always_ff @(posedge clk or negedge rst)
        if (!rst) status_q <= '0;
        else status_q <= status_d;
    assign status_out = status_q;
    assign offs_ext = {{(ADDR_W-OFFS_W){offset_in[OFFS_W-1]}}, offset_in};
    assign branch_taken_out = branch_taken_in & q;
    assign branch_addr_out = pc_in + (offs_ext << 2);
    assign hz_ex_wb_en = wb_en_in & in_valid;
    assign hz_ex_dest = dest_in;
    assign hz_mem_wb_en = wb_en_out & valid_out;
    assign hz_mem_dest = dest_out;
endmodule
